// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C pad-sharing arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        HOLDOFF
    } arb_state_e;

    localparam int M_NATV = 0;
    localparam int M_APB  = 1;

    // Request vector actually seen by the arbiter: static mode forces the
    // selected master on and the other one off.
    function automatic logic [1:0] eff_req(input logic       mode,
                                           input logic       sel,
                                           input logic [1:0] req);
        logic [1:0] r;
        if (mode) begin
            r = sel ? 2'b10 : 2'b01;
        end else begin
            r = req;
        end
        return r;
    endfunction

    // One-hot owner for a non-empty request; a tie goes to the master
    // that was not served last.
    function automatic logic [1:0] pick_owner(input logic [1:0] req,
                                              input logic       last_apb);
        logic [1:0] oh;
        if (req == 2'b11) begin
            oh = last_apb ? 2'b01 : 2'b10;
        end else begin
            oh = req;
        end
        return oh;
    endfunction

    // Pad bit taken from the granted master, or the idle level with no grant.
    function automatic logic pad_bit(input logic [1:0] gnt,
                                     input logic [1:0] val,
                                     input logic       idle_val);
        logic b;
        if (gnt == 2'b00) begin
            b = idle_val;
        end else begin
            b = |(gnt & val);
        end
        return b;
    endfunction

endpackage

// File: rtl/i2c_cond_det.sv
// Synchronises the SCL/SDA pad inputs and flags START, STOP and SCL edges.
module i2c_cond_det
    import i2c_arb_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic start_o,
    output logic stop_o,
    output logic scl_edge_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchroniser chains plus one history stage for edge detection.
    // NOTE: reset to 1 (idle bus level) so leaving reset never fakes an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every stage samples the previous-cycle value.
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // SDA transitions only count as bus conditions while SCL is stable high.
    assign start_o    = sda_prev_q & ~sda_s & scl_prev_q & scl_s;
    assign stop_o     = ~sda_prev_q & sda_s & scl_prev_q & scl_s;
    assign scl_edge_o = scl_s ^ scl_prev_q;

endmodule

// File: rtl/i2c_share_arb.sv
// Per-transaction owner arbiter for the shared I2C pads between the native
// and APB I2C masters: round-robin or static owner, bus-free holdoff and a
// stuck-bus timeout.
module i2c_share_arb
    import i2c_arb_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int BUS_FREE_CYC = 64,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_i,
    input  logic       sel_i,
    input  logic [1:0] req_i,
    input  logic [1:0] m_scl_o_i,
    input  logic [1:0] m_scl_oe_i,
    input  logic [1:0] m_sda_o_i,
    input  logic [1:0] m_sda_oe_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       scl_oe_o,
    output logic       sda_o,
    output logic       sda_oe_o,
    output logic [1:0] gnt_o,
    output logic       busy_o,
    output logic       to_irq_o
);

    localparam int HOLD_W = $clog2(BUS_FREE_CYC + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BUS_FREE_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_apb_q, last_apb_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              to_irq_q, to_irq_d;
    logic              busy_q;

    logic [1:0] req_eff;
    logic [1:0] owner_oh;
    logic       start, stop, scl_edge;

    i2c_cond_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond_det (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .start_o    (start),
        .stop_o     (stop),
        .scl_edge_o (scl_edge)
    );

    assign req_eff  = eff_req(mode_i, sel_i, req_i);
    assign owner_oh = pick_owner(req_eff, last_apb_q);

    // Next-state logic for the ownership FSM and its counters.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_apb_d = last_apb_q;
        hold_cnt_d = hold_cnt_q;
        to_cnt_d   = to_cnt_q;
        to_irq_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_eff) begin
                    gnt_d      = owner_oh;
                    last_apb_d = owner_oh[M_APB];
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // A START from either side claims the bus for the grantee.
                if (start && !stop) begin
                    to_cnt_d = '0;
                    state_d  = BUSY;
                end else if ((gnt_q & req_eff) == 2'b00) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (stop) begin
                    gnt_d      = 2'b00;
                    hold_cnt_d = '0;
                    state_d    = HOLDOFF;
                end else if (scl_edge) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q >= TO_LAST) begin
                    gnt_d      = 2'b00;
                    hold_cnt_d = '0;
                    to_irq_d   = 1'b1;
                    state_d    = HOLDOFF;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            HOLDOFF: begin
                gnt_d = 2'b00;
                // A foreign START means the bus is not free yet: restart.
                if (start && !stop) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; pads follow the next grant so
    // a release drops the enables in the same cycle as the grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            last_apb_q <= 1'b1;
            hold_cnt_q <= '0;
            to_cnt_q   <= '0;
            to_irq_q   <= 1'b0;
            busy_q     <= 1'b0;
            scl_o      <= 1'b1;
            scl_oe_o   <= 1'b0;
            sda_o      <= 1'b1;
            sda_oe_o   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_apb_q <= last_apb_d;
            hold_cnt_q <= hold_cnt_d;
            to_cnt_q   <= to_cnt_d;
            to_irq_q   <= to_irq_d;
            busy_q     <= (state_d == BUSY);
            scl_o      <= pad_bit(gnt_d, m_scl_o_i, 1'b1);
            scl_oe_o   <= pad_bit(gnt_d, m_scl_oe_i, 1'b0);
            sda_o      <= pad_bit(gnt_d, m_sda_o_i, 1'b1);
            sda_oe_o   <= pad_bit(gnt_d, m_sda_oe_i, 1'b0);
        end
    end

    assign gnt_o    = gnt_q;
    assign busy_o   = busy_q;
    assign to_irq_o = to_irq_q;

endmodule

// File: tb/tb_i2c_share_arb.sv
// Directed bench for the I2C pad-sharing arbiter.
module tb_i2c_share_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode, sel;
    logic [1:0] req, m_scl_o, m_scl_oe, m_sda_o, m_sda_oe;
    logic       scl, sda;
    logic       scl_o, scl_oe_o, sda_o, sda_oe_o;
    logic [1:0] gnt_o;
    logic       busy_o, to_irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_share_arb #(
        .SYNC_STAGES  (2),
        .BUS_FREE_CYC (64),
        .TIMEOUT_CYC  (100)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mode_i     (mode),
        .sel_i      (sel),
        .req_i      (req),
        .m_scl_o_i  (m_scl_o),
        .m_scl_oe_i (m_scl_oe),
        .m_sda_o_i  (m_sda_o),
        .m_sda_oe_i (m_sda_oe),
        .scl_i      (scl),
        .sda_i      (sda),
        .scl_o      (scl_o),
        .scl_oe_o   (scl_oe_o),
        .sda_o      (sda_o),
        .sda_oe_o   (sda_oe_o),
        .gnt_o      (gnt_o),
        .busy_o     (busy_o),
        .to_irq_o   (to_irq_o)
    );

    typedef struct {
        logic       mode;
        logic       sel;
        logic [1:0] req;
        logic [1:0] scl_o;
        logic [1:0] scl_oe;
        logic [1:0] sda_o;
        logic [1:0] sda_oe;
        logic [1:0] exp_gnt;
        logic [3:0] exp_pads;   // {scl_o, scl_oe, sda_o, sda_oe}
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pads();
        return {scl_o, scl_oe_o, sda_o, sda_oe_o};
    endfunction

    task automatic wait_busy(input logic v, input string name);
        int n = 0;
        while (busy_o !== v && n < 50) begin
            step();
            n++;
        end
        check(name, 32'(busy_o), 32'(v));
    endtask

    task automatic wait_grant(input int exp_cyc, input logic [1:0] exp_gnt, input string name);
        int n = 0;
        while (gnt_o == 2'b00 && n < 300) begin
            step();
            n++;
        end
        check({name, "_cycles"}, 32'(n), 32'(exp_cyc));
        check({name, "_gnt"}, 32'(gnt_o), 32'(exp_gnt));
    endtask

    initial begin
        int n;

        //            mode  sel   req    scl_o  scl_oe sda_o  sda_oe gnt    pads
        vecs[0] = '{1'b0, 1'b0, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b01, 4'b0110};
        vecs[1] = '{1'b0, 1'b0, 2'b11, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 4'b0111};
        vecs[2] = '{1'b0, 1'b0, 2'b11, 2'b10, 2'b01, 2'b10, 2'b11, 2'b01, 4'b0101};
        vecs[3] = '{1'b0, 1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10, 4'b1001};
        vecs[4] = '{1'b1, 1'b1, 2'b01, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 4'b0110};
        vecs[5] = '{1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 4'b1011};
        vecs[6] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010};
        vecs[7] = '{1'b1, 1'b1, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b10, 4'b1101};

        rst = 1'b1; mode = 1'b0; sel = 1'b0; req = 2'b00;
        m_scl_o = 2'b00; m_scl_oe = 2'b00; m_sda_o = 2'b00; m_sda_oe = 2'b00;
        scl = 1'b1; sda = 1'b1;
        step(); step();
        check("rst_gnt", 32'(gnt_o), 32'(2'b00));
        check("rst_busy", 32'(busy_o), 32'(1'b0));
        check("rst_irq", 32'(to_irq_o), 32'(1'b0));
        check("rst_pads", 32'(pads()), 32'(4'b1010));
        rst = 1'b0;
        step();

        // Single-cycle grant/release vectors from IDLE.
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode; sel = vecs[i].sel; req = vecs[i].req;
            m_scl_o = vecs[i].scl_o; m_scl_oe = vecs[i].scl_oe;
            m_sda_o = vecs[i].sda_o; m_sda_oe = vecs[i].sda_oe;
            step();
            check($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_pads", i), 32'(pads()), 32'(vecs[i].exp_pads));
            mode = 1'b0; req = 2'b00;
            step();
            check($sformatf("vec%0d_drop_gnt", i), 32'(gnt_o), 32'(2'b00));
            check($sformatf("vec%0d_drop_pads", i), 32'(pads()), 32'(4'b1010));
        end

        // Native transaction; native drops req mid-transfer while APB waits.
        req = 2'b01; m_scl_o = 2'b11; m_scl_oe = 2'b01; m_sda_o = 2'b11; m_sda_oe = 2'b01;
        step();
        check("s1_gnt", 32'(gnt_o), 32'(2'b01));
        sda = 1'b0;
        wait_busy(1'b1, "s1_busy");
        m_sda_o = 2'b10;
        step();
        check("s1_mirror_sda", 32'(sda_o), 32'(1'b0));
        m_sda_o = 2'b00; m_sda_oe = 2'b11;
        step();
        check("s1_mirror_pads", 32'(pads()), 32'(4'b1101));
        repeat (3) step();
        scl = 1'b0;
        repeat (3) begin
            repeat (2) step(); scl = 1'b1;
            repeat (2) step(); scl = 1'b0;
        end
        req = 2'b10;
        repeat (5) step();
        check("s1_hold_gnt", 32'(gnt_o), 32'(2'b01));
        check("s1_hold_busy", 32'(busy_o), 32'(1'b1));
        repeat (2) step();
        scl = 1'b1;
        repeat (4) step();
        sda = 1'b1;
        wait_busy(1'b0, "s1_stop");
        check("s1_holdoff_gnt", 32'(gnt_o), 32'(2'b00));
        check("s1_holdoff_pads", 32'(pads()), 32'(4'b1010));
        wait_grant(65, 2'b10, "s1_apb");

        // APB transaction with both requesting; foreign START restarts holdoff.
        req = 2'b11;
        sda = 1'b0;
        wait_busy(1'b1, "s2_busy");
        repeat (3) step(); scl = 1'b0;
        repeat (4) step(); scl = 1'b1;
        repeat (4) step(); sda = 1'b1;
        wait_busy(1'b0, "s2_stop");
        n = 0;
        repeat (20) begin step(); n++; end
        sda = 1'b0;
        repeat (10) begin step(); n++; end
        sda = 1'b1;
        while (gnt_o == 2'b00 && n < 300) begin step(); n++; end
        check("s2_restart_cycles", 32'(n), 32'(88));
        check("s2_rr_gnt", 32'(gnt_o), 32'(2'b01));
        req = 2'b00;
        step();
        check("s2_drop_gnt", 32'(gnt_o), 32'(2'b00));

        // Stuck bus: SCL held low in BUSY.
        req = 2'b01; m_scl_o = 2'b00; m_scl_oe = 2'b01; m_sda_o = 2'b00; m_sda_oe = 2'b01;
        step();
        check("s3_gnt", 32'(gnt_o), 32'(2'b01));
        sda = 1'b0;
        wait_busy(1'b1, "s3_busy");
        repeat (3) step();
        check("s3_oe_before", 32'(scl_oe_o), 32'(1'b1));
        scl = 1'b0;
        n = 0;
        while (to_irq_o !== 1'b1 && n < 300) begin step(); n++; end
        check("s3_to_cycles", 32'(n), 32'(103));
        check("s3_to_pads", 32'(pads()), 32'(4'b1010));
        check("s3_to_gnt", 32'(gnt_o), 32'(2'b00));
        check("s3_to_busy", 32'(busy_o), 32'(1'b0));
        step();
        check("s3_irq_pulse", 32'(to_irq_o), 32'(1'b0));
        req = 2'b00; scl = 1'b1;
        repeat (3) step();
        sda = 1'b1;
        repeat (70) step();

        // Static mode: sel change during BUSY applies only after holdoff.
        mode = 1'b1; sel = 1'b1; req = 2'b01;
        m_scl_o = 2'b11; m_scl_oe = 2'b10; m_sda_o = 2'b11; m_sda_oe = 2'b10;
        step();
        check("s4_gnt", 32'(gnt_o), 32'(2'b10));
        sda = 1'b0;
        wait_busy(1'b1, "s4_busy");
        sel = 1'b0;
        repeat (5) step();
        check("s4_hold_gnt", 32'(gnt_o), 32'(2'b10));
        sda = 1'b1;
        wait_busy(1'b0, "s4_stop");
        wait_grant(65, 2'b01, "s4_switch");
        mode = 1'b0; req = 2'b00;
        repeat (2) step();

        // Asynchronous reset in the middle of BUSY.
        req = 2'b01; m_scl_o = 2'b00; m_scl_oe = 2'b01; m_sda_o = 2'b00; m_sda_oe = 2'b01;
        step();
        check("s5_gnt", 32'(gnt_o), 32'(2'b01));
        sda = 1'b0;
        wait_busy(1'b1, "s5_busy");
        check("s5_oe_before", 32'(scl_oe_o), 32'(1'b1));
        rst = 1'b1;
        #1;
        check("s5_rst_pads", 32'(pads()), 32'(4'b1010));
        check("s5_rst_gnt", 32'(gnt_o), 32'(2'b00));
        check("s5_rst_busy", 32'(busy_o), 32'(1'b0));
        sda = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        check("s5_resume_gnt", 32'(gnt_o), 32'(2'b01));
        req = 2'b00;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
